// File: rtl/pipeline_hazard_sequencer.sv
// Stall/flush sequencer for the 5-stage pipeline: merges memory-wait, taken-branch and
// load-use hazards into per-stage write/bubble controls, with a memory timeout and stall counter.
module pipeline_hazard_sequencer #(
  parameter int unsigned WAIT_LIMIT = 15,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_mem_read,
  input  logic [3:0]       ex_rt,
  input  logic [3:0]       id_rs,
  input  logic [3:0]       id_rt,
  input  logic [2:0]       id_op,
  input  logic             mem_req,
  input  logic             mem_ready,
  input  logic             branch_taken,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             exmem_we,
  output logic             memwb_bubble,
  output logic             timeout,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [2:0] OpLw   = 3'b101;
  localparam logic [2:0] OpXori = 3'b001;
  localparam logic [7:0] WaitLimit = 8'(WAIT_LIMIT);

  typedef enum logic [1:0] {
    StRun,
    StMemWait,
    StHalt
  } state_e;

  state_e           state_q, state_d;
  logic [7:0]       wait_cnt_q, wait_cnt_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic lu;
  logic rt_is_src;

  // Controls for the "no memory hazard" case, shared by RUN and MEM_WAIT release.
  logic run_pc_we, run_ifid_we, run_ifid_flush, run_idex_bubble, run_exmem_we;

  // lw and xori write rt, so rt only creates a dependency for other opcodes.
  assign rt_is_src = (id_op != OpLw) && (id_op != OpXori);
  assign lu = ex_mem_read && ((ex_rt == id_rs) || ((ex_rt == id_rt) && rt_is_src));

  always_comb begin
    run_pc_we       = 1'b1;
    run_ifid_we     = 1'b1;
    run_ifid_flush  = 1'b0;
    run_idex_bubble = 1'b0;
    run_exmem_we    = 1'b1;
    if (branch_taken) begin
      run_ifid_flush  = 1'b1;
      run_idex_bubble = 1'b1;
    end else if (lu) begin
      run_pc_we       = 1'b0;
      run_ifid_we     = 1'b0;
      run_idex_bubble = 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    timeout_d    = timeout_q;
    pc_we        = run_pc_we;
    ifid_we      = run_ifid_we;
    ifid_flush   = run_ifid_flush;
    idex_bubble  = run_idex_bubble;
    exmem_we     = run_exmem_we;
    memwb_bubble = 1'b0;

    unique case (state_q)
      StRun: begin
        if (mem_req && !mem_ready) begin
          pc_we        = 1'b0;
          ifid_we      = 1'b0;
          ifid_flush   = 1'b0;
          idex_bubble  = 1'b0;
          exmem_we     = 1'b0;
          memwb_bubble = 1'b1;
          state_d      = StMemWait;
          wait_cnt_d   = 8'd1;
        end
      end
      StMemWait: begin
        if (mem_ready) begin
          state_d    = StRun;
          wait_cnt_d = 8'd0;
        end else begin
          pc_we        = 1'b0;
          ifid_we      = 1'b0;
          ifid_flush   = 1'b0;
          idex_bubble  = 1'b0;
          exmem_we     = 1'b0;
          memwb_bubble = 1'b1;
          if (wait_cnt_q < WaitLimit) begin
            wait_cnt_d = wait_cnt_q + 8'd1;
          end else begin
            state_d   = StHalt;
            timeout_d = 1'b1;
          end
        end
      end
      StHalt: begin
        pc_we        = 1'b0;
        ifid_we      = 1'b0;
        ifid_flush   = 1'b0;
        idex_bubble  = 1'b1;
        exmem_we     = 1'b0;
        memwb_bubble = 1'b1;
      end
      default: begin
        state_d = StRun;
      end
    endcase

    if (rst) begin
      pc_we        = 1'b0;
      ifid_we      = 1'b0;
      exmem_we     = 1'b0;
      ifid_flush   = 1'b1;
      idex_bubble  = 1'b1;
      memwb_bubble = 1'b1;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!pc_we && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StRun;
      wait_cnt_q  <= 8'd0;
      timeout_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      timeout_q   <= timeout_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign timeout   = timeout_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_sequencer.sv
// Scoreboard bench: directed hazard vectors push expected controls; a negedge monitor checks them.
module tb_pipeline_hazard_sequencer;

  localparam logic [5:0] CRst  = 6'b001101;
  localparam logic [5:0] CFrz  = 6'b000001;
  localparam logic [5:0] CRun  = 6'b110010;
  localparam logic [5:0] CLu   = 6'b000110;
  localparam logic [5:0] CBr   = 6'b111110;
  localparam logic [5:0] CHalt = 6'b000101;

  typedef struct {
    int         id;
    logic [5:0] ctl;
    logic       to;
    logic [3:0] cnt;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ex_mem_read = 1'b0;
  logic [3:0] ex_rt = 4'h0, id_rs = 4'h0, id_rt = 4'h0;
  logic [2:0] id_op = 3'b000;
  logic       mem_req = 1'b0, mem_ready = 1'b0, branch_taken = 1'b0;
  logic       pc_we, ifid_we, ifid_flush, idex_bubble, exmem_we, memwb_bubble, timeout;
  logic [3:0] stall_cnt;

  exp_t       sb[$];
  int         total = 0;
  int         bad = 0;
  int         step_id = 0;
  logic [3:0] exp_cnt = 4'h0;

  always #5 clk = ~clk;

  pipeline_hazard_sequencer #(
    .WAIT_LIMIT(4),
    .CNT_W     (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ex_mem_read (ex_mem_read),
    .ex_rt       (ex_rt),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_op       (id_op),
    .mem_req     (mem_req),
    .mem_ready   (mem_ready),
    .branch_taken(branch_taken),
    .pc_we       (pc_we),
    .ifid_we     (ifid_we),
    .ifid_flush  (ifid_flush),
    .idex_bubble (idex_bubble),
    .exmem_we    (exmem_we),
    .memwb_bubble(memwb_bubble),
    .timeout     (timeout),
    .stall_cnt   (stall_cnt)
  );

  task automatic step(input logic r, input logic emr, input logic [3:0] ert, input logic [3:0] irs,
                      input logic [3:0] irt, input logic [2:0] op, input logic mq,
                      input logic mr, input logic br, input logic [5:0] ctl, input logic to);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; ex_mem_read = emr; ex_rt = ert; id_rs = irs; id_rt = irt; id_op = op;
    mem_req = mq; mem_ready = mr; branch_taken = br;
    step_id++;
    e.id = step_id; e.ctl = ctl; e.to = to; e.cnt = exp_cnt;
    sb.push_back(e);
    if (r) exp_cnt = 4'h0;
    else if (!ctl[5] && exp_cnt != 4'hF) exp_cnt = exp_cnt + 4'h1;
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t       e;
      logic [5:0] act;
      e = sb.pop_front();
      act = {pc_we, ifid_we, ifid_flush, idex_bubble, exmem_we, memwb_bubble};
      total++;
      if (act !== e.ctl || timeout !== e.to || stall_cnt !== e.cnt) begin
        bad++;
        $display("FAIL step%0d: ctl=%b timeout=%b cnt=%0d, required ctl=%b timeout=%b cnt=%0d",
                 e.id, act, timeout, stall_cnt, e.ctl, e.to, e.cnt);
      end
    end
  end

  initial begin
    // reset, then load-use on rs
    step(1, 0, 4'h0, 4'h0, 4'h0, 3'b000, 0, 0, 0, CRst, 0);
    step(0, 0, 4'h0, 4'h0, 4'h0, 3'b000, 0, 0, 0, CRun, 0);
    step(0, 1, 4'h3, 4'h3, 4'h0, 3'b000, 0, 0, 0, CLu,  0);
    step(0, 0, 4'h3, 4'h3, 4'h0, 3'b000, 0, 0, 0, CRun, 0);
    // rt exemption for lw/xori, dependency for other opcodes
    step(0, 1, 4'h5, 4'h0, 4'h5, 3'b101, 0, 0, 0, CRun, 0);
    step(0, 1, 4'h5, 4'h0, 4'h5, 3'b001, 0, 0, 0, CRun, 0);
    step(0, 1, 4'h5, 4'h0, 4'h5, 3'b010, 0, 0, 0, CLu,  0);
    step(0, 0, 4'h0, 4'h0, 4'h0, 3'b000, 0, 0, 0, CRun, 0);
    // three-cycle memory wait then release, then a single-cycle access
    step(1, 0, 4'h0, 4'h0, 4'h0, 3'b000, 0, 0, 0, CRst, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 4'h0, 4'h0, 4'h0, 3'b000, 1, 0, 0, CFrz, 0);
    step(0, 0, 4'h0, 4'h0, 4'h0, 3'b000, 1, 1, 0, CRun, 0);
    step(0, 0, 4'h0, 4'h0, 4'h0, 3'b000, 1, 1, 0, CRun, 0);
    // memory beats branch and load-use; release applies the branch immediately
    step(0, 1, 4'h3, 4'h3, 4'h0, 3'b000, 1, 0, 1, CFrz, 0);
    step(0, 1, 4'h3, 4'h3, 4'h0, 3'b000, 1, 0, 1, CFrz, 0);
    step(0, 1, 4'h3, 4'h3, 4'h0, 3'b000, 1, 1, 1, CBr,  0);
    step(0, 1, 4'h3, 4'h3, 4'h0, 3'b000, 0, 0, 0, CLu,  0);
    step(0, 0, 4'h0, 4'h0, 4'h0, 3'b000, 0, 0, 0, CRun, 0);
    // timeout: entry cycle + 4 waits frozen, then HALT; counter saturates at 4'hF
    for (int i = 0; i < 5; i++) step(0, 0, 4'h0, 4'h0, 4'h0, 3'b000, 1, 0, 0, CFrz, 0);
    for (int i = 0; i < 20; i++) begin
      step(0, 1, 4'h3, 4'h3, 4'h0, 3'b000, 1, i[0], i[1], CHalt, 1);
    end
    step(1, 0, 4'h0, 4'h0, 4'h0, 3'b000, 0, 0, 0, CRst, 1);
    step(0, 0, 4'h0, 4'h0, 4'h0, 3'b000, 0, 0, 0, CRun, 0);
    step(0, 0, 4'h0, 4'h0, 4'h0, 3'b000, 0, 0, 1, CBr,  0);
    // reset in the middle of a memory wait
    step(0, 0, 4'h0, 4'h0, 4'h0, 3'b000, 1, 0, 0, CFrz, 0);
    step(1, 0, 4'h0, 4'h0, 4'h0, 3'b000, 1, 0, 0, CRst, 0);
    step(0, 0, 4'h0, 4'h0, 4'h0, 3'b000, 0, 0, 0, CRun, 0);

    for (int i = 0; i < 5 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: pending=%0d, required 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
